clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Multi-channel programmable clock/tick generator; successor to the fixed 50MHz->5Hz divider.
//  Each channel has its own runtime period, high time (duty) and enable.
//  Reconfiguration is glitch-free: new settings apply only at a period boundary.
//  Feeds display scan, debounce sampling and LED blink logic from one system clock.
// PARAMETERS
//  NCH         4           number of output channels (1..16)
//  W           32          counter / config width
//  DEF_PERIOD  10_000_000  reset period in clk cycles (5Hz @ 50MHz)
//  DEF_HIGH    5_000_000   reset high time in clk cycles (50% duty)
//  STOP_MODE   1           0: en low stops at once; 1: en low finishes current period
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              reset; asynchronous, active-low
//  en          in   NCH            per-channel run enable, level
//  cfg_we      in   1              config write strobe, one cycle
//  cfg_ch      in   $clog2(NCH)+1  target channel
//  cfg_period  in   W              period P in clk cycles
//  cfg_high    in   W              high time H in clk cycles
//  cfg_err     out  1              one-cycle pulse: last write rejected
//  clk_o       out  NCH            divided clock per channel, registered
//  tick_o      out  NCH            one-cycle pulse at last cycle of each period
//  busy_o      out  NCH            channel in RUN
//  pending_o   out  NCH            shadow config written, not yet applied
// BEHAVIOUR
//  Reset: cnt=0, P_act=DEF_PERIOD, H_act=DEF_HIGH, all state IDLE; all outputs 0.
//  Per-channel FSM, states IDLE and RUN:
//   IDLE: cnt=0, clk_o=0, tick_o=0. If en=1: go to RUN with cnt=0.
//   RUN, each cycle: cnt <= (cnt==P_act-1) ? 0 : cnt+1.
//   The wrap cycle (cnt==P_act-1) is the period boundary.
//   RUN, en=0 with STOP_MODE=0: next cycle is IDLE and outputs are 0.
//   RUN, en=0 with STOP_MODE=1: keep running through the boundary, then go to IDLE.
//    en back to 1 before the boundary cancels the stop.
//  Output timing (registered, no combinational path from inputs):
//   while RUN: clk_o == (cnt < H_act) and tick_o == (cnt == P_act-1), for the current cnt.
//   So clk_o is high for exactly H cycles and low for P-H cycles.
//   The first cycle after IDLE->RUN shows cnt=0 with clk_o=1.
//  Config:
//   A write is valid when 2 <= P < 2^W, 1 <= H <= P-1 and cfg_ch < NCH.
//   Invalid write: ignored, cfg_err pulses the next cycle, no state changes.
//   Valid write: stored in the channel shadow and pending_o=1.
//   Channel IDLE: shadow copied to P_act/H_act on the next edge; pending_o clears.
//   Channel RUN: shadow copied at the period boundary; pending_o clears the same edge.
//   Write in the boundary cycle itself: applies at that boundary, so the next period uses it.
//   Multiple writes before a boundary: last one wins.
//  Arithmetic: unsigned W-bit compares only; cnt never exceeds P_act-1; no overflow possible.
//  Reset mid-operation: asynchronous clear to the reset state above.
//   Shadow and pending are lost; P_act/H_act return to defaults.
// STRUCTURE
//  Package clk_div_pkg holds:
//   FSM state encoding (ST_IDLE, ST_RUN)
//   default constants (DEF_PERIOD, DEF_HIGH)
//   cfg validity function
//  Sub-module clk_div_chan: one channel (FSM, counter, active and shadow regs, outputs).
//  Top: config decode/validation, cfg_err register, generate loop of NCH clk_div_chan.
// TESTING (bench overrides DEF_PERIOD=10, DEF_HIGH=5, NCH=2)
//  1 Reset, en=01 -> ch0: clk_o 5 high/5 low, tick_o every 10th cycle at cnt=9; ch1 outputs stay 0.
//  2 Mid-period write ch0 P=4,H=1 -> current 10-cycle period completes, then 1 high/3 low.
//    pending_o[0] is 1 until the boundary edge.
//  3 Writes P=1,H=0 / P=6,H=6 / cfg_ch=2 -> cfg_err pulses one cycle each; all channels unchanged.
//  4 STOP_MODE=1, en drop at cnt=3 -> runs to cnt=9, tick_o pulses, then IDLE with outputs 0.
//    STOP_MODE=0 -> outputs 0 the next cycle.
//  5 Write exactly in the boundary cycle, P=3,H=2 -> the very next period is 2 high/1 low.
//  6 rst_n low mid-period, asynchronously -> all outputs 0 at once.
//    After release with en=1: default 5/5 waveform restarts from cnt=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable multi-channel clock divider:
// channel state encoding, reset defaults and the config validity rule.
package clk_div_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } chan_state_t;

   localparam int unsigned DEF_PERIOD = 10_000_000;
   localparam int unsigned DEF_HIGH   = 5_000_000;

   // Operands arrive zero-extended to 64 bits, so any W up to 64 is covered.
   // P < 2^W holds for every W-bit value, so only the lower bounds need checking.
   function automatic logic cfg_valid(input logic [63:0] period,
                                      input logic [63:0] high,
                                      input logic [31:0] ch,
                                      input logic [31:0] nch);
      return (period >= 64'd2) && (high >= 64'd1) && (high < period) && (ch < nch);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN control, period counter, active and shadow
// configuration, and registered clock/tick outputs.
module clk_div_chan #(
   parameter int unsigned W          = 32,
   parameter int unsigned DEF_PERIOD = clk_div_pkg::DEF_PERIOD,
   parameter int unsigned DEF_HIGH   = clk_div_pkg::DEF_HIGH,
   parameter int unsigned STOP_MODE  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         wr,
   input  logic [W-1:0] wr_period,
   input  logic [W-1:0] wr_high,
   output logic         clk_o,
   output logic         tick_o,
   output logic         busy_o,
   output logic         pending_o
);
   import clk_div_pkg::*;

   chan_state_t  st, nxt_st;
   logic [W-1:0] cnt, p_act, h_act, sh_p, sh_h;
   logic [W-1:0] nxt_cnt, nxt_p, nxt_h, nxt_sp, nxt_sh;
   logic         pend, nxt_pend, wrap;

   assign wrap      = (st == ST_RUN) && (cnt == p_act - W'(1));
   assign busy_o    = (st == ST_RUN);
   assign pending_o = pend;

   // Active settings only change at a period boundary or while idle, which
   // keeps cnt below P_act at all times and the output free of runt pulses.
   always_comb begin
      nxt_st   = st;
      nxt_cnt  = cnt;
      nxt_p    = p_act;
      nxt_h    = h_act;
      nxt_sp   = sh_p;
      nxt_sh   = sh_h;
      nxt_pend = pend;

      if (wr) begin
         nxt_sp   = wr_period;
         nxt_sh   = wr_high;
         nxt_pend = 1'b1;
      end

      if (wrap && (wr || pend)) begin
         nxt_p    = wr ? wr_period : sh_p;
         nxt_h    = wr ? wr_high : sh_h;
         nxt_pend = 1'b0;
      end else if ((st == ST_IDLE) && pend) begin
         nxt_p    = sh_p;
         nxt_h    = sh_h;
         nxt_pend = wr;
      end

      case (st)
         ST_IDLE: begin
            nxt_cnt = '0;
            if (en) nxt_st = ST_RUN;
         end
         default: begin
            nxt_cnt = wrap ? '0 : cnt + W'(1);
            if (!en && ((STOP_MODE == 0) || wrap)) begin
               nxt_st  = ST_IDLE;
               nxt_cnt = '0;
            end
         end
      endcase
   end

   // Outputs are computed from the next-state values so they line up with
   // the counter value they describe, with no combinational path to ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= ST_IDLE;
         cnt    <= '0;
         p_act  <= W'(DEF_PERIOD);
         h_act  <= W'(DEF_HIGH);
         sh_p   <= '0;
         sh_h   <= '0;
         pend   <= 1'b0;
         clk_o  <= 1'b0;
         tick_o <= 1'b0;
      end else begin
         st     <= nxt_st;
         cnt    <= nxt_cnt;
         p_act  <= nxt_p;
         h_act  <= nxt_h;
         sh_p   <= nxt_sp;
         sh_h   <= nxt_sh;
         pend   <= nxt_pend;
         clk_o  <= (nxt_st == ST_RUN) && (nxt_cnt < nxt_h);
         tick_o <= (nxt_st == ST_RUN) && (nxt_cnt == nxt_p - W'(1));
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/tick generator: validates config writes,
// flags rejected ones on cfg_err and steers accepted ones to a channel.
module clk_div_prog #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned W          = 32,
   parameter int unsigned DEF_PERIOD = clk_div_pkg::DEF_PERIOD,
   parameter int unsigned DEF_HIGH   = clk_div_pkg::DEF_HIGH,
   parameter int unsigned STOP_MODE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       en,
   input  logic                 cfg_we,
   input  logic [$clog2(NCH):0] cfg_ch,
   input  logic [W-1:0]         cfg_period,
   input  logic [W-1:0]         cfg_high,
   output logic                 cfg_err,
   output logic [NCH-1:0]       clk_o,
   output logic [NCH-1:0]       tick_o,
   output logic [NCH-1:0]       busy_o,
   output logic [NCH-1:0]       pending_o
);
   import clk_div_pkg::*;

   localparam int CHW = $clog2(NCH) + 1;

   logic           cfg_ok;
   logic [NCH-1:0] wr;

   assign cfg_ok = cfg_valid(64'(cfg_period), 64'(cfg_high), 32'(cfg_ch), NCH);

   // A rejected write touches no channel; it only raises cfg_err for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_err <= 1'b0;
      else        cfg_err <= cfg_we && !cfg_ok;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign wr[i] = cfg_we && cfg_ok && (cfg_ch == CHW'(i));

      clk_div_chan #(
         .W          (W),
         .DEF_PERIOD (DEF_PERIOD),
         .DEF_HIGH   (DEF_HIGH),
         .STOP_MODE  (STOP_MODE)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en[i]),
         .wr        (wr[i]),
         .wr_period (cfg_period),
         .wr_high   (cfg_high),
         .clk_o     (clk_o[i]),
         .tick_o    (tick_o[i]),
         .busy_o    (busy_o[i]),
         .pending_o (pending_o[i])
      );
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: two instances (finish-period stop and
// immediate stop) share stimulus and are checked against a cycle-level model.
module tb_clk_div_prog;

   localparam int NCH = 2;
   localparam int W   = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] en = '0;
   logic           cfg_we = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [W-1:0]   cfg_period = '0;
   logic [W-1:0]   cfg_high = '0;

   logic           err0, err1;
   logic [NCH-1:0] clk0, tick0, busy0, pend0;
   logic [NCH-1:0] clk1, tick1, busy1, pend1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clk_div_prog #(.NCH(NCH), .W(W), .DEF_PERIOD(10), .DEF_HIGH(5), .STOP_MODE(0)) dut_s0 (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(err0),
      .clk_o(clk0), .tick_o(tick0), .busy_o(busy0), .pending_o(pend0)
   );

   clk_div_prog #(.NCH(NCH), .W(W), .DEF_PERIOD(10), .DEF_HIGH(5), .STOP_MODE(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(err1),
      .clk_o(clk1), .tick_o(tick1), .busy_o(busy1), .pending_o(pend1)
   );

   typedef struct packed {
      logic [1:0] clk;
      logic [1:0] tick;
      logic [1:0] busy;
      logic [1:0] pend;
      logic       err;
   } obs_t;

   typedef struct {
      obs_t d0;
      obs_t d1;
   } exp_t;

   exp_t expQ[$];

   // Reference state per instance d (0: immediate stop, 1: finish period) and channel c.
   int unsigned mPos[2][2], mP[2][2], mH[2][2], mShP[2][2], mShH[2][2];
   bit          mRun[2][2], mPend[2][2];
   bit          mErr[2];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] e, input logic we, input logic [1:0] ch,
                                input logic [31:0] p, input logic [31:0] h);
      en         = e;
      cfg_we     = we;
      cfg_ch     = ch;
      cfg_period = p;
      cfg_high   = h;
      @(negedge clk);
   endtask

   function automatic void modelReset();
      for (int d = 0; d < 2; d++) begin
         mErr[d] = 1'b0;
         for (int c = 0; c < 2; c++) begin
            mPos[d][c]  = 0;
            mP[d][c]    = 10;
            mH[d][c]    = 5;
            mShP[d][c]  = 0;
            mShH[d][c]  = 0;
            mRun[d][c]  = 1'b0;
            mPend[d][c] = 1'b0;
         end
      end
   endfunction

   // One clock edge of the spec's rules for instance d.
   function automatic void modelStep(input int d, input bit finishPeriod);
      bit ok;
      ok = (cfg_period >= 32'd2) && (cfg_high >= 32'd1) && (cfg_high < cfg_period) && (cfg_ch < 2'd2);
      mErr[d] = cfg_we && !ok;
      for (int c = 0; c < 2; c++) begin
         bit wr;
         wr = cfg_we && ok && (int'(cfg_ch) == c);
         if (mRun[d][c] && (mPos[d][c] == mP[d][c] - 1)) begin
            if (wr) begin
               mP[d][c] = cfg_period;
               mH[d][c] = cfg_high;
            end else if (mPend[d][c]) begin
               mP[d][c] = mShP[d][c];
               mH[d][c] = mShH[d][c];
            end
            mPend[d][c] = 1'b0;
            mPos[d][c]  = 0;
            if (!en[c]) mRun[d][c] = 1'b0;
         end else if (mRun[d][c]) begin
            mPos[d][c] = mPos[d][c] + 1;
            if (wr) begin
               mShP[d][c]  = cfg_period;
               mShH[d][c]  = cfg_high;
               mPend[d][c] = 1'b1;
            end
            if (!en[c] && !finishPeriod) begin
               mRun[d][c] = 1'b0;
               mPos[d][c] = 0;
            end
         end else begin
            if (mPend[d][c]) begin
               mP[d][c]    = mShP[d][c];
               mH[d][c]    = mShH[d][c];
               mPend[d][c] = 1'b0;
            end
            if (wr) begin
               mShP[d][c]  = cfg_period;
               mShH[d][c]  = cfg_high;
               mPend[d][c] = 1'b1;
            end
            mPos[d][c] = 0;
            if (en[c]) mRun[d][c] = 1'b1;
         end
      end
   endfunction

   function automatic obs_t modelObs(input int d);
      obs_t o;
      o = '0;
      for (int c = 0; c < 2; c++) begin
         o.clk[c]  = mRun[d][c] && (mPos[d][c] < mH[d][c]);
         o.tick[c] = mRun[d][c] && (mPos[d][c] == mP[d][c] - 1);
         o.busy[c] = mRun[d][c];
         o.pend[c] = mPend[d][c];
      end
      o.err = mErr[d];
      return o;
   endfunction

   // Model advances on every edge and queues what the DUTs should show next.
   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         modelReset();
      end else begin
         modelStep(0, 1'b0);
         modelStep(1, 1'b1);
      end
      e.d0 = modelObs(0);
      e.d1 = modelObs(1);
      expQ.push_back(e);
   end

   // Monitor: pops one expectation per edge and compares after outputs settle.
   always @(posedge clk) begin
      exp_t got;
      #1;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard at %0t: got empty queue, required one entry", $time);
      end else begin
         got = expQ.pop_front();
         checkOutput("clk_o s0",     32'(clk0),  32'(got.d0.clk));
         checkOutput("tick_o s0",    32'(tick0), 32'(got.d0.tick));
         checkOutput("busy_o s0",    32'(busy0), 32'(got.d0.busy));
         checkOutput("pending_o s0", 32'(pend0), 32'(got.d0.pend));
         checkOutput("cfg_err s0",   32'(err0),  32'(got.d0.err));
         checkOutput("clk_o s1",     32'(clk1),  32'(got.d1.clk));
         checkOutput("tick_o s1",    32'(tick1), 32'(got.d1.tick));
         checkOutput("busy_o s1",    32'(busy1), 32'(got.d1.busy));
         checkOutput("pending_o s1", 32'(pend1), 32'(got.d1.pend));
         checkOutput("cfg_err s1",   32'(err1),  32'(got.d1.err));
      end
   end

   // Waits at negedges until channel 0 of the finish-period model reaches a count.
   task automatic waitForPos(input bit atBoundary, input int unsigned target, input string what);
      int n;
      n = 0;
      while (!(mRun[1][0] && (atBoundary ? (mPos[1][0] == mP[1][0] - 1) : (mPos[1][0] == target)))
             && (n < 60)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got timeout after %0d cycles, required position reached", what, n);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] rEn;
      rEn = 2'b11;
      $display("[TB] starting");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] default 5/5 waveform on channel 0");
      repeat (25) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] enable drop at cnt=3");
      waitForPos(1'b0, 3, "wait cnt3");
      repeat (15) applyStimulus(2'b00, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] mid-period write P=4 H=1");
      repeat (4) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);
      applyStimulus(2'b01, 1'b1, 2'd0, 32'd4, 32'd1);
      repeat (20) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] rejected writes");
      applyStimulus(2'b01, 1'b1, 2'd0, 32'd1, 32'd0);
      applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);
      applyStimulus(2'b01, 1'b1, 2'd0, 32'd6, 32'd6);
      applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);
      applyStimulus(2'b01, 1'b1, 2'd2, 32'd6, 32'd3);
      repeat (6) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] write in the boundary cycle P=3 H=2");
      waitForPos(1'b1, 0, "wait boundary");
      applyStimulus(2'b01, 1'b1, 2'd0, 32'd3, 32'd2);
      repeat (12) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] asynchronous reset mid-period");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset s0", 32'({clk0, tick0, busy0, pend0, err0}), 32'd0);
      checkOutput("async reset s1", 32'({clk1, tick1, busy1, pend1, err1}), 32'd0);
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) applyStimulus(2'b01, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) rEn = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            applyStimulus(rEn, 1'b1, 2'($urandom_range(0, 2)),
                          32'($urandom_range(0, 9)), 32'($urandom_range(0, 9)));
         else
            applyStimulus(rEn, 1'b0, 2'd0, 32'd0, 32'd0);
      end

      repeat (12) applyStimulus(2'b00, 1'b0, 2'd0, 32'd0, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
